fp_div_seq: RTL

Parametrised sequential IEEE-754-style floating-point divider computing res = n / x. It uses restoring division that produces one quotient bit per cycle, then normalises and rounds to nearest-even. Zero, infinity and NaN operands are handled on a short fast path, and exception flags are reported. It is the reusable arithmetic FSM for the datapath labs and supports single, half or custom formats through its parameters.

---
 rtl/fp_div_seq.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential restoring floating-point divider, res = n / x
//
// Purpose:
//   Radix-2 restoring divider for an IEEE-754-style format set by EXP_W/MAN_W.
//   One quotient bit is produced per cycle. The quotient is then normalised and
//   rounded to nearest-even. Zero, infinity and NaN operands take a short path
//   straight from UNPACK to DONE. Subnormal operands and results flush to zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any operation in flight
//   r_i          start request, honoured only in IDLE
//   n, x         dividend and divisor, captured on the accepting edge
//   res          registered result, held until a new result is loaded
//   r_o          one-cycle done pulse
//   busy         high while an operation is in flight (state != IDLE)
//   div_by_zero  finite nonzero divided by zero
//   invalid      NaN operand, 0/0 or inf/inf
//   overflow     result exponent too large, result forced to signed infinity
//   underflow    result below the smallest normal, flushed to signed zero
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_i,
    input  logic [EXP_W+MAN_W:0]     n,
    input  logic [EXP_W+MAN_W:0]     x,
    output logic [EXP_W+MAN_W:0]     res,
    output logic                     r_o,
    output logic                     busy,
    output logic                     div_by_zero,
    output logic                     invalid,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int Q  = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(Q + 1);

    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic [CW-1:0]        CNT_LAST = CW'(Q - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [W-1:0]           r_n;
    logic [W-1:0]           r_x;
    logic [MAN_W:0]         r_b;
    logic [MAN_W+1:0]       r_rem;
    logic [Q-1:0]           r_q;
    logic [CW-1:0]          r_cnt;
    logic signed [EW-1:0]   r_e;
    logic                   r_sign;
    logic                   r_sticky;
    logic [W-1:0]           r_res;
    logic                   r_r_o;
    logic                   r_busy;
    logic                   r_dbz;
    logic                   r_invalid;
    logic                   r_overflow;
    logic                   r_underflow;

    // Operand fields and classification
    logic [EXP_W-1:0] w_n_exp;
    logic [EXP_W-1:0] w_x_exp;
    logic [MAN_W-1:0] w_n_frac;
    logic [MAN_W-1:0] w_x_frac;
    logic             w_n_zero;
    logic             w_x_zero;
    logic             w_n_inf;
    logic             w_x_inf;
    logic             w_n_nan;
    logic             w_x_nan;
    logic             w_sign;

    assign w_n_exp  = r_n[W-2:MAN_W];
    assign w_x_exp  = r_x[W-2:MAN_W];
    assign w_n_frac = r_n[MAN_W-1:0];
    assign w_x_frac = r_x[MAN_W-1:0];
    assign w_n_zero = (w_n_exp == '0);
    assign w_x_zero = (w_x_exp == '0);
    assign w_n_inf  = (w_n_exp == EXP_ONES) && (w_n_frac == '0);
    assign w_x_inf  = (w_x_exp == EXP_ONES) && (w_x_frac == '0);
    assign w_n_nan  = (w_n_exp == EXP_ONES) && (w_n_frac != '0);
    assign w_x_nan  = (w_x_exp == EXP_ONES) && (w_x_frac != '0);
    assign w_sign   = r_n[W-1] ^ r_x[W-1];

    logic [W-1:0] w_qnan;
    logic [W-1:0] w_inf;
    logic [W-1:0] w_zero;

    assign w_qnan = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    assign w_inf  = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
    assign w_zero = {w_sign, {(W-1){1'b0}}};

    // Fast-path decode; order matters: invalid cases win over divide-by-zero,
    // and inf/0 is a plain infinity without the divide-by-zero flag.
    logic         w_special;
    logic [W-1:0] w_spec_res;
    logic         w_spec_inv;
    logic         w_spec_dbz;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = w_zero;
        w_spec_inv = 1'b0;
        w_spec_dbz = 1'b0;
        if (w_n_nan || w_x_nan || (w_n_zero && w_x_zero) || (w_n_inf && w_x_inf)) begin
            w_spec_res = w_qnan;
            w_spec_inv = 1'b1;
        end else if (w_x_zero) begin
            w_spec_res = w_inf;
            w_spec_dbz = !w_n_inf;
        end else if (w_n_inf) begin
            w_spec_res = w_inf;
        end else if (w_x_inf || w_n_zero) begin
            w_spec_res = w_zero;
        end else begin
            w_special = 1'b0;
        end
    end

    // Biased quotient exponent, wide enough to hold both out-of-range directions
    logic signed [EW-1:0] w_e_init;
    assign w_e_init = $signed({2'b00, w_n_exp}) - $signed({2'b00, w_x_exp}) + BIAS;

    // One restoring step
    logic             w_ge;
    logic [MAN_W+1:0] w_rem_sub;
    assign w_ge      = (r_rem >= {1'b0, r_b});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;

    // Quotient is in (0.5, 2): at most one left shift brings the leading one to Q-1
    logic [Q-1:0] w_q_norm;
    assign w_q_norm = r_q[Q-1] ? r_q : {r_q[Q-2:0], 1'b0};

    // Rounding: q = [hidden][MAN_W fraction bits][guard][round][lowest]
    logic [MAN_W-1:0]     w_frac;
    logic                 w_guard;
    logic                 w_round;
    logic                 w_inc;
    logic [MAN_W:0]       w_mant;
    logic                 w_carry;
    logic signed [EW-1:0] w_e_rnd;

    assign w_frac  = r_q[Q-2:3];
    assign w_guard = r_q[2];
    assign w_round = r_q[1];
    assign w_inc   = w_guard && (w_round || r_sticky || w_frac[0]);
    assign w_mant  = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    assign w_carry = w_mant[MAN_W];
    assign w_e_rnd = r_e + $signed({{(EW-1){1'b0}}, w_carry});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_x         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_e         <= '0;
            r_sign      <= 1'b0;
            r_sticky    <= 1'b0;
            r_res       <= '0;
            r_r_o       <= 1'b0;
            r_busy      <= 1'b0;
            r_dbz       <= 1'b0;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_i) begin
                        r_n         <= n;
                        r_x         <= x;
                        r_dbz       <= 1'b0;
                        r_invalid   <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_res     <= w_spec_res;
                        r_invalid <= w_spec_inv;
                        r_dbz     <= w_spec_dbz;
                        r_r_o     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_b     <= {1'b1, w_x_frac};
                        r_rem   <= {2'b01, w_n_frac};
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_e     <= w_e_init;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[MAN_W:0], 1'b0};
                    r_q   <= {r_q[Q-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_q      <= w_q_norm;
                    r_e      <= r_q[Q-1] ? r_e : (r_e - 1'b1);
                    r_sticky <= (|r_rem) | w_q_norm[0];
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_e_rnd >= E_MAX) begin
                        r_res      <= {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                        r_overflow <= 1'b1;
                    end else if (w_e_rnd <= E_ZERO) begin
                        r_res       <= {r_sign, {(W-1){1'b0}}};
                        r_underflow <= 1'b1;
                    end else begin
                        // On carry-out the fraction bits of w_mant are already zero
                        r_res <= {r_sign, w_e_rnd[EXP_W-1:0], w_mant[MAN_W-1:0]};
                    end
                    r_r_o   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_r_o   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res         = r_res;
    assign r_o         = r_r_o;
    assign busy        = r_busy;
    assign div_by_zero = r_dbz;
    assign invalid     = r_invalid;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
